// File: rtl/heap_pq_pkg.sv
// rtl/heap_pq_pkg.sv - shared state encoding and heap index helpers for heap_pq
package heap_pq_pkg;

    // Wide enough for the right child of the deepest legal node (2*254+2).
    localparam int IDX_W = 9;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SIFT_UP,
        SIFT_DOWN
    } state_t;

    function automatic idx_t parent_idx(input idx_t i);
        return (i - idx_t'(1)) >> 1;
    endfunction

    function automatic idx_t left_idx(input idx_t i);
        return (i << 1) + idx_t'(1);
    endfunction

    function automatic idx_t right_idx(input idx_t i);
        return (i << 1) + idx_t'(2);
    endfunction

endpackage

// File: rtl/heap_pq_cmp.sv
// rtl/heap_pq_cmp.sv - signed "better-than" comparator; HEAP_PQ_MAXHEAP_EN selects max-heap ordering
module heap_pq_cmp #(
    parameter int KEY_W = 32
) (
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    output logic             better
);

`ifdef HEAP_PQ_MAXHEAP_EN
    assign better = $signed(a) > $signed(b);
`else
    assign better = $signed(a) < $signed(b);
`endif

endmodule

// File: rtl/heap_pq.sv
// rtl/heap_pq.sv - binary-heap priority queue with push, pop and replace handshakes (HEAP_PQ_MAXHEAP_EN: max-heap)
module heap_pq
    import heap_pq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    state_t           state, state_nxt;
    idx_t             cursor, cursor_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [KEY_W-1:0] heap [DEPTH];

    idx_t             cnt_idx, par_idx, l_idx, r_idx, sel_idx;
    logic [KEY_W-1:0] cur_key, par_key, l_key, r_key, sel_key, last_key;
    logic             has_child, up_better, r_beats_l, dn_better;
    logic             push_ok, pop_ok, do_push, do_pop, do_repl;
    logic             wr0_en, wr1_en;
    idx_t             wr0_idx, wr1_idx;
    logic [KEY_W-1:0] wr0_key, wr1_key;

    function automatic logic [KEY_W-1:0] rd(input idx_t idx);
        logic [KEY_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == idx_t'(i)) v = heap[i];
        end
        return v;
    endfunction

    assign cnt_idx  = idx_t'(count);
    assign par_idx  = parent_idx(cursor);
    assign l_idx    = left_idx(cursor);
    assign r_idx    = right_idx(cursor);
    assign cur_key  = rd(cursor);
    assign par_key  = rd(par_idx);
    assign l_key    = rd(l_idx);
    assign r_key    = rd(r_idx);
    assign last_key = rd(cnt_idx - idx_t'(1));

    assign has_child = l_idx < cnt_idx;
    assign sel_idx   = (r_idx < cnt_idx && r_beats_l) ? r_idx : l_idx;
    assign sel_key   = rd(sel_idx);

    heap_pq_cmp #(.KEY_W(KEY_W)) u_cmp_up    (.a(cur_key), .b(par_key), .better(up_better));
    heap_pq_cmp #(.KEY_W(KEY_W)) u_cmp_child (.a(r_key),   .b(l_key),   .better(r_beats_l));
    heap_pq_cmp #(.KEY_W(KEY_W)) u_cmp_down  (.a(sel_key), .b(cur_key), .better(dn_better));

    assign in_ready  = (state == IDLE) && !full;
    assign out_valid = (state == IDLE) && !empty;
    assign out_key   = heap[0];
    assign full      = count == CNT_W'(DEPTH);
    assign empty     = count == '0;
    assign busy      = state != IDLE;

    assign push_ok = in_valid && in_ready;
    assign pop_ok  = out_valid && out_ready;
    assign do_push = push_ok && !pop_ok;
    assign do_pop  = pop_ok && !in_valid;
    assign do_repl = push_ok && pop_ok;

    // A swap that lands on the root or on a leaf finishes the sift immediately,
    // so no cycle is spent re-checking a node that cannot move further.
    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        count_nxt  = count;
        wr0_en     = 1'b0;
        wr0_idx    = '0;
        wr0_key    = '0;
        wr1_en     = 1'b0;
        wr1_idx    = '0;
        wr1_key    = '0;
        case (state)
            IDLE: begin
                if (do_push) begin
                    wr0_en     = 1'b1;
                    wr0_idx    = cnt_idx;
                    wr0_key    = in_key;
                    count_nxt  = count + CNT_W'(1);
                    cursor_nxt = cnt_idx;
                    state_nxt  = SIFT_UP;
                end else if (do_repl) begin
                    wr0_en     = 1'b1;
                    wr0_key    = in_key;
                    cursor_nxt = '0;
                    state_nxt  = SIFT_DOWN;
                end else if (do_pop) begin
                    wr0_en     = 1'b1;
                    wr0_key    = last_key;
                    count_nxt  = count - CNT_W'(1);
                    cursor_nxt = '0;
                    state_nxt  = (count > CNT_W'(2)) ? SIFT_DOWN : IDLE;
                end
            end
            SIFT_UP: begin
                if (cursor == '0 || !up_better) begin
                    state_nxt = IDLE;
                end else begin
                    wr0_en     = 1'b1;
                    wr0_idx    = cursor;
                    wr0_key    = par_key;
                    wr1_en     = 1'b1;
                    wr1_idx    = par_idx;
                    wr1_key    = cur_key;
                    cursor_nxt = par_idx;
                    state_nxt  = (par_idx == '0) ? IDLE : SIFT_UP;
                end
            end
            SIFT_DOWN: begin
                if (!has_child || !dn_better) begin
                    state_nxt = IDLE;
                end else begin
                    wr0_en     = 1'b1;
                    wr0_idx    = cursor;
                    wr0_key    = sel_key;
                    wr1_en     = 1'b1;
                    wr1_idx    = sel_idx;
                    wr1_key    = cur_key;
                    cursor_nxt = sel_idx;
                    state_nxt  = (left_idx(sel_idx) < cnt_idx) ? SIFT_DOWN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state  <= IDLE;
            cursor <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            cursor <= cursor_nxt;
            count  <= count_nxt;
        end
    end

    always_ff @(posedge system1000) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr1_en && wr1_idx == idx_t'(i)) heap[i] <= wr1_key;
            else if (wr0_en && wr0_idx == idx_t'(i)) heap[i] <= wr0_key;
        end
    end

endmodule

// File: tb/tb_heap_pq.sv
// tb/tb_heap_pq.sv - randomized self-checking bench for heap_pq against a queue reference model
module tb_heap_pq;

    localparam int DEPTH   = 8;
    localparam int KEY_W   = 32;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int MAX_LAT = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [KEY_W-1:0] out_key;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int q[$];

    heap_pq #(.DEPTH(DEPTH), .KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_key          (in_key),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_key         (out_key),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_better(input int a, input int b);
`ifdef HEAP_PQ_MAXHEAP_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    function automatic int m_best_pos();
        int p = 0;
        for (int i = 1; i < q.size(); i++) if (m_better(q[i], q[p])) p = i;
        return p;
    endfunction

    function automatic int m_take_best();
        int p = m_best_pos();
        int v = q[p];
        q.delete(p);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 32) begin
            step();
            cyc++;
        end
    endtask

    task automatic drive_push(input int k, output int cyc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        in_key   = KEY_W'(k);
        step();
        in_valid = 1'b0;
        wait_idle(cyc);
    endtask

    task automatic drive_pop(output logic [KEY_W-1:0] k, output int cyc);
        int n = 0;
        while (out_valid !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        k = out_key;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_idle(cyc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_key = 32'd77;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_release_count got %0d exp 0", count); end
        q.delete();
    endtask

    task automatic test_basic_order();
        int keys[4] = '{5, 3, 8, 1};
`ifdef HEAP_PQ_MAXHEAP_EN
        int exp[4] = '{8, 5, 3, 1};
`else
        int exp[4] = '{1, 3, 5, 8};
`endif
        int cyc;
        logic [KEY_W-1:0] got;
        do_reset();
        foreach (keys[i]) begin
            drive_push(keys[i], cyc);
            checks++; if (count !== CNT_W'(i + 1)) begin errors++; $display("FAIL basic_push_count got %0d exp %0d", count, i + 1); end
        end
        foreach (exp[i]) begin
            drive_pop(got, cyc);
            checks++; if (got !== KEY_W'(exp[i])) begin errors++; $display("FAIL basic_pop%0d got %0d exp %0d", i, $signed(got), exp[i]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
    endtask

    task automatic test_full();
        int cyc;
        logic [KEY_W-1:0] got;
        do_reset();
        for (int k = 7; k >= 0; k--) begin
            drive_push(k, cyc);
            q.push_back(k);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_valid = 1'b1;
        in_key = 32'd9;
        repeat (4) step();
        in_valid = 1'b0;
        checks++; if (count !== CNT_W'(DEPTH)) begin errors++; $display("FAIL full_hold_count got %0d exp %0d", count, DEPTH); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_hold_busy got %b exp 0", busy); end
        while (q.size() > 0) begin
            int e = m_take_best();
            drive_pop(got, cyc);
            checks++; if (got !== KEY_W'(e)) begin errors++; $display("FAIL full_drain got %0d exp %0d", $signed(got), e); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_replace();
        int cyc, e;
        logic [KEY_W-1:0] got;
        do_reset();
        foreach (q[i]) ;
        for (int k = 2; k <= 6; k += 2) begin
            drive_push(k, cyc);
            q.push_back(k);
        end
        e = m_take_best();
        q.push_back(5);
        got = out_key;
        in_valid = 1'b1;
        in_key = 32'd5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_idle(cyc);
        checks++; if (got !== KEY_W'(e)) begin errors++; $display("FAIL replace_out got %0d exp %0d", $signed(got), e); end
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL replace_count got %0d exp 3", count); end
        checks++; if (cyc > MAX_LAT) begin errors++; $display("FAIL replace_latency got %0d exp <=%0d", cyc, MAX_LAT); end
        while (q.size() > 0) begin
            e = m_take_best();
            drive_pop(got, cyc);
            checks++; if (got !== KEY_W'(e)) begin errors++; $display("FAIL replace_drain got %0d exp %0d", $signed(got), e); end
        end
    endtask

    task automatic test_signed();
        int cyc;
        do_reset();
        drive_push(0, cyc);
        q.push_back(0);
        drive_push(10, cyc);
        q.push_back(10);
        drive_push(-1, cyc);
        q.push_back(-1);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL signed_busy_cycles got %0d exp 1", cyc); end
        checks++; if (out_key !== KEY_W'(q[m_best_pos()])) begin errors++; $display("FAIL signed_root got %0d exp %0d", $signed(out_key), q[m_best_pos()]); end
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL signed_count got %0d exp 3", count); end
    endtask

    task automatic test_reset_mid_sift();
        int cyc;
        logic [KEY_W-1:0] got;
        do_reset();
        for (int k = 10; k <= 40; k += 10) drive_push(k, cyc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsift_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL midsift_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midsift_empty got %b exp 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midsift_busy got %b exp 0", busy); end
        step();
        rst_n = 1'b1;
        step();
        q.delete();
        drive_push(42, cyc);
        drive_pop(got, cyc);
        checks++; if (got !== KEY_W'(42)) begin errors++; $display("FAIL midsift_repush got %0d exp 42", $signed(got)); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midsift_final_empty got %b exp 1", empty); end
    endtask

    task automatic test_random();
        int cyc, op, k, e;
        logic [KEY_W-1:0] got;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 2);
            k  = $urandom_range(0, 40) - 20;
            if (op == 0 && q.size() < DEPTH) begin
                drive_push(k, cyc);
                q.push_back(k);
            end else if (op == 1 && q.size() > 0) begin
                e = m_take_best();
                drive_pop(got, cyc);
                checks++; if (got !== KEY_W'(e)) begin errors++; $display("FAIL rand_pop got %0d exp %0d", $signed(got), e); end
            end else if (op == 2 && q.size() > 0 && q.size() < DEPTH) begin
                e = m_take_best();
                q.push_back(k);
                got = out_key;
                in_valid = 1'b1;
                in_key = KEY_W'(k);
                out_ready = 1'b1;
                step();
                in_valid = 1'b0;
                out_ready = 1'b0;
                wait_idle(cyc);
                checks++; if (got !== KEY_W'(e)) begin errors++; $display("FAIL rand_replace got %0d exp %0d", $signed(got), e); end
            end else begin
                cyc = 0;
            end
            checks++; if (cyc > MAX_LAT) begin errors++; $display("FAIL rand_latency got %0d exp <=%0d", cyc, MAX_LAT); end
            checks++; if (count !== CNT_W'(q.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, q.size()); end
            checks++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_full got %b exp %b", full, q.size() == DEPTH); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_key = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic_order();
        test_full();
        test_replace();
        test_signed();
        test_reset_mid_sift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heap_pq.md
HEAP_PQ -- requirements
Module: heap_pq

Interface
REQ-001 Parameter DEPTH, default 8, maximum number of stored keys; legal range 2..255.
REQ-002 Parameter KEY_W, default 32, key width in bits; keys are signed two's complement.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 system1000  in  1  sole clock; all state updates on its rising edge.
REQ-005 system1000_rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  push request.
REQ-007 in_ready  out  1  push accepted when high together with in_valid.
REQ-008 in_key  in  KEY_W  key to push.
REQ-009 out_valid  out  1  out_key holds the current root.
REQ-010 out_ready  in  1  pop request.
REQ-011 out_key  out  KEY_W  root key (minimum, or maximum per REQ-031).
REQ-012 count  out  CNT_W  number of stored keys.
REQ-013 full  out  1  count == DEPTH.
REQ-014 empty  out  1  count == 0.
REQ-015 busy  out  1  sift in progress (state != IDLE).

Function
REQ-016 Storage is a register array heap[0..DEPTH-1] in implicit binary-heap order: parent(i) = (i-1)/2, children 2i+1 and 2i+2.
REQ-017 States are IDLE, SIFT_UP and SIFT_DOWN; a cursor register holds the active index.
REQ-018 in_ready = (state == IDLE) && !full; out_valid = (state == IDLE) && !empty; neither depends combinationally on the other handshake input.
REQ-019 A push (in_valid && in_ready && !(out_valid && out_ready)) writes in_key to heap[count], increments count, loads the cursor with the old count, and enters SIFT_UP.
REQ-020 SIFT_UP, per cycle: if cursor == 0 or heap[cursor] is not strictly better than heap[parent], go to IDLE; else swap the two and set cursor = parent.
REQ-021 A pop (out_valid && out_ready && !in_valid) moves heap[count-1] to heap[0], decrements count, and sets cursor = 0; it enters SIFT_DOWN if the new count > 1, else IDLE.
REQ-022 SIFT_DOWN, per cycle: select the strictly better child among the children whose index < count (the left child wins ties); if there is no child or the selected child is not strictly better, go to IDLE; else swap and set cursor = child.
REQ-023 Simultaneous push and pop (both handshakes complete in one cycle) is a replace: heap[0] = in_key, count unchanged, cursor = 0, enter SIFT_DOWN.
REQ-024 Equal keys never swap.
REQ-025 Latency back to IDLE is one cycle for the operation plus at most floor(log2(DEPTH)) sift cycles.
REQ-026 out_key is driven from heap[0] and is meaningful only while out_valid is high.
REQ-027 count, full and empty reflect the registered count and update in the same cycle as the operation.

Reset
REQ-028 Asserting system1000_rstn low immediately forces state = IDLE, count = 0 and cursor = 0, which makes in_ready = 1, out_valid = 0, full = 0, empty = 1 and busy = 0.
REQ-029 Heap array contents are not reset; reset asserted mid-sift discards the operation.
REQ-030 Handshakes are ignored while reset is asserted.

Configuration
REQ-031 With HEAP_PQ_MAXHEAP_EN defined, "better" means signed-greater and the root is the maximum.
REQ-032 Without HEAP_PQ_MAXHEAP_EN, "better" means signed-less and the root is the minimum.
REQ-033 The macro changes neither the ports nor the timing.

Structure
REQ-034 A shared package heap_pq_pkg holds the state enum (IDLE, SIFT_UP, SIFT_DOWN) and the parent and child index helper functions.
REQ-035 One sub-module, heap_pq_cmp, is a combinational KEY_W signed "better-than" comparator and is the only place that reads HEAP_PQ_MAXHEAP_EN.

Verification
REQ-036 Min build, DEPTH=8: after reset, push 5,3,8,1 (each waiting for in_ready), then pop four times -> out_key sequence 1,3,5,8, and after the last pop empty = 1.
REQ-037 Fill to DEPTH=8 with keys 7..0 -> full = 1 and in_ready = 0; a held in_valid with key 9 is not accepted and count stays 8.
REQ-038 With heap {2,4,6}, drive push of 5 and pop in the same cycle -> count stays 3 and the subsequent pops return 4,5,6.
REQ-039 Push -1 into heap {0,10} -> after sift, out_key = -1 (signed compare); busy is high for exactly 1 sift cycle.
REQ-040 Assert reset during a SIFT_DOWN -> the same cycle shows count = 0, empty = 1, busy = 0, and a new push of 42 then pop returns 42.
REQ-041 HEAP_PQ_MAXHEAP_EN build: push 5,3,8,1 -> pops return 8,5,3,1.
